sme_job_sequencer: RTL and testbench

Front-end scheduler for the string-matching engine (SME). It holds one host-written subject string and accepts pattern-match jobs from N_REQ requesters, granted round-robin. For each job it replays the string and then the pattern into the SME's serial load port, waits for the SME result, and returns it tagged with the requester id. The string is re-sent before every job because an SME compare leaves its internal string rotated.

---
 rtl/sme_pkg.sv | 28 ++
 rtl/sme_rr_arbiter.sv | 30 +++
 rtl/sme_job_sequencer.sv | 259 +++++++++++++++++++++++++
 tb/tb_sme_job_sequencer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sme_pkg.sv
// Shared definitions for the string-matching-engine job sequencer:
// FSM state encoding, buffer limits, SME metacharacters and a small
// pattern-length helper.
package sme_pkg;

    localparam int STR_MAX = 32;
    localparam int PAT_MAX = 8;

    localparam logic [7:0] CH_HAT    = 8'h5E;
    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_DOT    = 8'h2E;
    localparam logic [7:0] CH_STAR   = 8'h2A;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_STR  = 3'd1,
        ST_GAP  = 3'd2,
        ST_PAT  = 3'd3,
        ST_WAIT = 3'd4,
        ST_RSP  = 3'd5
    } state_e;

    // A pattern length is usable when it is non-zero and fits the SME.
    function automatic logic pat_len_ok(input logic [3:0] len);
        return (len != 4'd0) && (len <= 4'(PAT_MAX));
    endfunction

endpackage

// File: rtl/sme_rr_arbiter.sv
// Combinational round-robin arbiter: searches the request vector starting
// at ptr_i and returns a one-hot grant plus its binary index.
module sme_rr_arbiter #(
    parameter int N_REQ = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [1:0]       ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [1:0]       gnt_id_o,
    output logic             gnt_valid_o
);

    // Walk from the farthest slot back to ptr_i so the nearest request wins.
    always_comb begin
        gnt_o       = '0;
        gnt_id_o    = 2'd0;
        gnt_valid_o = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_i[(int'(ptr_i) + k) % N_REQ]) begin
                gnt_o                                = '0;
                gnt_o[(int'(ptr_i) + k) % N_REQ]     = 1'b1;
                gnt_id_o                             = 2'((int'(ptr_i) + k) % N_REQ);
                gnt_valid_o                          = 1'b1;
            end else begin
                gnt_valid_o = gnt_valid_o;
            end
        end
    end

endmodule

// File: rtl/sme_job_sequencer.sv
// Front-end scheduler for the SME: keeps one host string, grants pattern
// jobs round-robin, replays string + gap + pattern into the SME load port,
// waits (bounded) for the result and returns it tagged with the requester.
// Every SME/requester-facing output is a register one cycle behind the
// state register, which is why the wait terminal count below is offset.
module sme_job_sequencer
    import sme_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int TIMEOUT = 48
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 str_wr_en_i,
    input  logic                 str_wr_first_i,
    input  logic [7:0]           str_wr_data_i,
    output logic                 str_wr_ready_o,
    input  logic [N_REQ-1:0]     req_valid_i,
    input  logic [N_REQ*64-1:0]  req_pat_i,
    input  logic [N_REQ*4-1:0]   req_len_i,
    output logic [N_REQ-1:0]     req_ready_o,
    output logic                 sme_isstring_o,
    output logic                 sme_ispattern_o,
    output logic [7:0]           sme_chardata_o,
    input  logic                 sme_valid_i,
    input  logic                 sme_match_i,
    input  logic [4:0]           sme_match_index_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [1:0]           rsp_id_o,
    output logic                 rsp_match_o,
    output logic [4:0]           rsp_index_o,
    output logic                 rsp_err_o,
    output logic                 rsp_timeout_o
);

    // WAIT is entered in the state register one cycle before the SME sees
    // ispattern fall, so the terminal count covers TIMEOUT+1 observable cycles.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT + 1);

    state_e               state_q, state_d;
    logic [5:0]           idx_q, idx_d;
    logic [7:0]           wcnt_q, wcnt_d;
    logic [1:0]           rr_q, rr_d;
    logic [63:0]          pat_q, pat_d;
    logic [3:0]           len_q, len_d;
    logic [1:0]           id_q, id_d;
    logic [N_REQ-1:0]     req_ready_q, req_ready_d;
    logic                 isstr_q, isstr_d, ispat_q, ispat_d;
    logic [7:0]           char_q, char_d;
    logic                 wr_ready_q, wr_ready_d;
    logic                 rsp_valid_q, rsp_valid_d, rsp_match_q, rsp_match_d;
    logic [4:0]           rsp_index_q, rsp_index_d;
    logic [1:0]           rsp_id_q, rsp_id_d;
    logic                 rsp_err_q, rsp_err_d, rsp_to_q, rsp_to_d;
    logic [5:0]           str_len_q;
    logic [7:0]           str_mem_q [STR_MAX];
    logic                 wr_acc_s;
    logic [N_REQ-1:0]     gnt_s;
    logic [1:0]           gnt_id_s;
    logic                 gnt_valid_s;

    assign wr_acc_s = str_wr_en_i & wr_ready_q;

    sme_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req_i       (req_valid_i),
        .ptr_i       (rr_q),
        .gnt_o       (gnt_s),
        .gnt_id_o    (gnt_id_s),
        .gnt_valid_o (gnt_valid_s)
    );

    // String length: restart on a first byte, otherwise append and saturate.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            str_len_q <= 6'd0;
        end else if (wr_acc_s) begin
            if (str_wr_first_i) begin
                str_len_q <= 6'd1;
            end else if (!str_len_q[5]) begin
                str_len_q <= str_len_q + 6'd1;
            end
        end
    end

    // String storage; bytes beyond the buffer depth are dropped.
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            if (str_wr_first_i) begin
                str_mem_q[0] <= str_wr_data_i;
            end else if (!str_len_q[5]) begin
                str_mem_q[str_len_q[4:0]] <= str_wr_data_i;
            end
        end
    end

    // Next-state and next-output logic for the job FSM.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        wcnt_d      = wcnt_q;
        rr_d        = rr_q;
        pat_d       = pat_q;
        len_d       = len_q;
        id_d        = id_q;
        req_ready_d = '0;
        isstr_d     = 1'b0;
        ispat_d     = 1'b0;
        char_d      = 8'd0;
        rsp_valid_d = rsp_valid_q;
        rsp_match_d = rsp_match_q;
        rsp_index_d = rsp_index_q;
        rsp_id_d    = rsp_id_q;
        rsp_err_d   = rsp_err_q;
        rsp_to_d    = rsp_to_q;
        case (state_q)
            ST_IDLE: begin
                if (wr_ready_q && !str_wr_en_i && (str_len_q != 6'd0) && gnt_valid_s) begin
                    req_ready_d = gnt_s;
                    id_d        = gnt_id_s;
                    pat_d       = req_pat_i[int'(gnt_id_s)*64 +: 64];
                    len_d       = req_len_i[int'(gnt_id_s)*4 +: 4];
                    rr_d        = (gnt_id_s == 2'(N_REQ - 1)) ? 2'd0 : gnt_id_s + 2'd1;
                    idx_d       = 6'd0;
                    state_d     = pat_len_ok(req_len_i[int'(gnt_id_s)*4 +: 4]) ? ST_STR : ST_RSP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_STR: begin
                isstr_d = 1'b1;
                char_d  = str_mem_q[idx_q[4:0]];
                if (idx_q == str_len_q - 6'd1) begin
                    idx_d   = 6'd0;
                    state_d = ST_GAP;
                end else begin
                    idx_d = idx_q + 6'd1;
                end
            end
            ST_GAP: begin
                state_d = ST_PAT;
            end
            ST_PAT: begin
                ispat_d = 1'b1;
                char_d  = pat_q[int'(idx_q[2:0])*8 +: 8];
                if (idx_q == {2'b00, len_q} - 6'd1) begin
                    idx_d   = 6'd0;
                    wcnt_d  = 8'd0;
                    state_d = ST_WAIT;
                end else begin
                    idx_d = idx_q + 6'd1;
                end
            end
            ST_WAIT: begin
                wcnt_d = wcnt_q + 8'd1;
                if (sme_valid_i) begin
                    rsp_valid_d = 1'b1;
                    rsp_match_d = sme_match_i;
                    rsp_index_d = sme_match_index_i;
                    rsp_id_d    = id_q;
                    rsp_err_d   = 1'b0;
                    rsp_to_d    = 1'b0;
                    state_d     = ST_RSP;
                end else if (wcnt_q == WAIT_LAST) begin
                    rsp_valid_d = 1'b1;
                    rsp_match_d = 1'b0;
                    rsp_index_d = 5'd0;
                    rsp_id_d    = id_q;
                    rsp_err_d   = 1'b0;
                    rsp_to_d    = 1'b1;
                    state_d     = ST_RSP;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_RSP: begin
                // Arriving here without a response pending means a bad length.
                if (!rsp_valid_q) begin
                    rsp_valid_d = 1'b1;
                    rsp_match_d = 1'b0;
                    rsp_index_d = 5'd0;
                    rsp_id_d    = id_q;
                    rsp_err_d   = 1'b1;
                    rsp_to_d    = 1'b0;
                end else if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    rsp_match_d = 1'b0;
                    rsp_index_d = 5'd0;
                    rsp_id_d    = 2'd0;
                    rsp_err_d   = 1'b0;
                    rsp_to_d    = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_RSP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        wr_ready_d = (state_d == ST_IDLE);
    end

    // Job FSM state, captured job and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            idx_q       <= 6'd0;
            wcnt_q      <= 8'd0;
            rr_q        <= 2'd0;
            pat_q       <= 64'd0;
            len_q       <= 4'd0;
            id_q        <= 2'd0;
            req_ready_q <= '0;
            isstr_q     <= 1'b0;
            ispat_q     <= 1'b0;
            char_q      <= 8'd0;
            wr_ready_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_match_q <= 1'b0;
            rsp_index_q <= 5'd0;
            rsp_id_q    <= 2'd0;
            rsp_err_q   <= 1'b0;
            rsp_to_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            wcnt_q      <= wcnt_d;
            rr_q        <= rr_d;
            pat_q       <= pat_d;
            len_q       <= len_d;
            id_q        <= id_d;
            req_ready_q <= req_ready_d;
            isstr_q     <= isstr_d;
            ispat_q     <= ispat_d;
            char_q      <= char_d;
            wr_ready_q  <= wr_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_match_q <= rsp_match_d;
            rsp_index_q <= rsp_index_d;
            rsp_id_q    <= rsp_id_d;
            rsp_err_q   <= rsp_err_d;
            rsp_to_q    <= rsp_to_d;
        end
    end

    assign str_wr_ready_o  = wr_ready_q;
    assign req_ready_o     = req_ready_q;
    assign sme_isstring_o  = isstr_q;
    assign sme_ispattern_o = ispat_q;
    assign sme_chardata_o  = char_q;
    assign rsp_valid_o     = rsp_valid_q;
    assign rsp_id_o        = rsp_id_q;
    assign rsp_match_o     = rsp_match_q;
    assign rsp_index_o     = rsp_index_q;
    assign rsp_err_o       = rsp_err_q;
    assign rsp_timeout_o   = rsp_to_q;

endmodule

// File: tb/tb_sme_job_sequencer.sv
// Directed bench for sme_job_sequencer: drives host string writes and
// requester jobs, plays a simple SME, and checks strobe sequences, response
// latency/fields, round-robin order, backpressure, overflow and reset.
module tb_sme_job_sequencer;

    localparam int N_REQ   = 2;
    localparam int TIMEOUT = 48;

    logic         clk = 1'b0;
    logic         reset;
    logic         str_wr_en, str_wr_first;
    logic [7:0]   str_wr_data;
    logic         str_wr_ready;
    logic [1:0]   req_valid;
    logic [127:0] req_pat;
    logic [7:0]   req_len;
    logic [1:0]   req_ready;
    logic         sme_isstring, sme_ispattern;
    logic [7:0]   sme_chardata;
    logic         sme_valid, sme_match;
    logic [4:0]   sme_match_index;
    logic         rsp_valid, rsp_ready;
    logic [1:0]   rsp_id;
    logic         rsp_match;
    logic [4:0]   rsp_index;
    logic         rsp_err, rsp_timeout;
    logic [23:0]  all_outs;

    int           n_tests = 0;
    int           n_fail  = 0;
    logic [7:0]   exp_str [32];
    int           exp_ls  = 0;
    logic [7:0]   pat_b [2][8];

    always #5 clk = ~clk;

    assign all_outs = {str_wr_ready, req_ready, sme_isstring, sme_ispattern, sme_chardata,
                       rsp_valid, rsp_id, rsp_match, rsp_index, rsp_err, rsp_timeout};

    sme_job_sequencer #(.N_REQ(N_REQ), .TIMEOUT(TIMEOUT)) dut (
        .clk               (clk),
        .reset             (reset),
        .str_wr_en_i       (str_wr_en),
        .str_wr_first_i    (str_wr_first),
        .str_wr_data_i     (str_wr_data),
        .str_wr_ready_o    (str_wr_ready),
        .req_valid_i       (req_valid),
        .req_pat_i         (req_pat),
        .req_len_i         (req_len),
        .req_ready_o       (req_ready),
        .sme_isstring_o    (sme_isstring),
        .sme_ispattern_o   (sme_ispattern),
        .sme_chardata_o    (sme_chardata),
        .sme_valid_i       (sme_valid),
        .sme_match_i       (sme_match),
        .sme_match_index_i (sme_match_index),
        .rsp_valid_o       (rsp_valid),
        .rsp_ready_i       (rsp_ready),
        .rsp_id_o          (rsp_id),
        .rsp_match_o       (rsp_match),
        .rsp_index_o       (rsp_index),
        .rsp_err_o         (rsp_err),
        .rsp_timeout_o     (rsp_timeout)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One host byte write; the bench keeps its own copy of the string.
    task automatic wr_byte(input logic first, input logic [7:0] d);
        str_wr_en    = 1'b1;
        str_wr_first = first;
        str_wr_data  = d;
        if (first) begin
            exp_str[0] = d;
            exp_ls     = 1;
        end else if (exp_ls < 32) begin
            exp_str[exp_ls] = d;
            exp_ls++;
        end
        @(negedge clk);
        str_wr_en    = 1'b0;
        str_wr_first = 1'b0;
    endtask

    task automatic set_pat(input int id, input string s, input int len);
        req_pat[id*64 +: 64] = 64'd0;
        for (int k = 0; k < s.len(); k++) begin
            req_pat[id*64 + k*8 +: 8] = s[k];
            pat_b[id][k]              = s[k];
        end
        req_len[id*4 +: 4] = 4'(len);
    endtask

    // Run one job end to end. sme_lat < 0 means the SME never answers.
    task automatic do_job(input int exp_id, input int lp, input int sme_lat,
                          input logic exp_err, input logic exp_to, input logic m,
                          input logic [4:0] ix, input int hold, input logic keep);
        int t, bad, rsp_c, exp_rsp, w, stab_bad;
        logic       is_s, is_p;
        logic [7:0] ch;
        logic [1:0] oh;
        logic [9:0] snap;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (req_ready == 2'b00 && t < 100);
        oh = 2'd1 << exp_id;
        check_eq("grant", 64'(req_ready), 64'(oh));
        check_eq("wr_ready_at_T", 64'(str_wr_ready), 64'd0);
        if (!keep) req_valid = 2'b00;
        w       = exp_ls + lp + 2;
        exp_rsp = exp_err ? 1 : ((sme_lat >= 0) ? w + sme_lat + 1 : w + TIMEOUT + 1);
        bad     = 0;
        rsp_c   = -1;
        for (int c = 1; c < 300; c++) begin
            @(negedge clk);
            is_s = !exp_err && c <= exp_ls;
            is_p = !exp_err && c >= exp_ls + 2 && c <= exp_ls + lp + 1;
            ch   = is_s ? exp_str[c-1] : (is_p ? pat_b[exp_id][c-exp_ls-2] : 8'd0);
            if (sme_isstring !== is_s || sme_ispattern !== is_p || sme_chardata !== ch ||
                str_wr_ready !== 1'b0 || req_ready !== 2'b00) begin
                if (bad == 0) $display("strobe deviation at cycle T+%0d", c);
                bad++;
            end
            if (rsp_valid) begin
                rsp_c = c;
                break;
            end
            // The pulse at c==1 lands outside WAIT and must be ignored.
            sme_valid       = (sme_lat >= 0) && (c == w + sme_lat || c == 1);
            sme_match       = (c == 1) ? 1'b1 : m;
            sme_match_index = (c == 1) ? 5'd31 : ix;
        end
        sme_valid = 1'b0;
        check_eq("rsp_latency", 64'(rsp_c), 64'(exp_rsp));
        check_eq("strobes", 64'(bad), 64'd0);
        check_eq("rsp_id", 64'(rsp_id), 64'(exp_id));
        check_eq("rsp_match", 64'(rsp_match), 64'(m));
        check_eq("rsp_index", 64'(rsp_index), 64'(ix));
        check_eq("rsp_err", 64'(rsp_err), 64'(exp_err));
        check_eq("rsp_timeout", 64'(rsp_timeout), 64'(exp_to));
        if (hold > 0) begin
            snap     = {rsp_valid, rsp_id, rsp_match, rsp_index, rsp_err};
            stab_bad = 0;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                if ({rsp_valid, rsp_id, rsp_match, rsp_index, rsp_err} !== snap ||
                    req_ready !== 2'b00) stab_bad++;
            end
            check_eq("backpressure_stable", 64'(stab_bad), 64'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check_eq("rsp_drop", 64'(rsp_valid), 64'd0);
    endtask

    initial begin
        int t;
        string hw;
        reset = 1'b1; str_wr_en = 1'b0; str_wr_first = 1'b0; str_wr_data = 8'd0;
        req_valid = 2'b00; req_pat = 128'd0; req_len = 8'd0;
        sme_valid = 1'b0; sme_match = 1'b0; sme_match_index = 5'd0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_outs", 64'(all_outs), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("wr_ready_idle", 64'(str_wr_ready), 64'd1);

        // Basic job.
        hw = "hello world";
        for (int i = 0; i < hw.len(); i++) wr_byte(i == 0, hw[i]);
        set_pat(0, "wor", 3);
        req_valid = 2'b01;
        do_job(0, 3, 2, 1'b0, 1'b0, 1'b1, 5'd6, 0, 1'b0);

        // Round robin: pointer sits at 1 after the first job.
        set_pat(0, "o", 1);
        set_pat(1, "ld", 2);
        req_valid = 2'b11;
        do_job(1, 2, 0, 1'b0, 1'b0, 1'b1, 5'd9, 0, 1'b1);
        do_job(0, 1, 5, 1'b0, 1'b0, 1'b1, 5'd4, 0, 1'b1);
        do_job(1, 2, 1, 1'b0, 1'b0, 1'b1, 5'd9, 0, 1'b0);

        // Bad lengths 0 and 9.
        set_pat(0, "", 0);
        req_valid = 2'b01;
        do_job(0, 0, -1, 1'b1, 1'b0, 1'b0, 5'd0, 0, 1'b0);
        set_pat(1, "abcdefgh", 9);
        req_valid = 2'b10;
        do_job(1, 9, -1, 1'b1, 1'b0, 1'b0, 5'd0, 0, 1'b0);

        // Timeout.
        set_pat(0, "hel", 3);
        req_valid = 2'b01;
        do_job(0, 3, -1, 1'b0, 1'b1, 1'b0, 5'd0, 0, 1'b0);

        // Backpressure with the other requester waiting.
        set_pat(1, "wo", 2);
        set_pat(0, "d", 1);
        req_valid = 2'b11;
        do_job(1, 2, 3, 1'b0, 1'b0, 1'b1, 5'd6, 5, 1'b1);
        do_job(0, 1, 0, 1'b0, 1'b0, 1'b1, 5'd10, 0, 1'b0);

        // Overflow: 40 writes, bytes 0x20.. include $ * . metachars.
        for (int i = 0; i < 40; i++) wr_byte(i == 0, 8'h20 + 8'(i));
        check_eq("model_len", 64'(exp_ls), 64'd32);
        set_pat(0, "^.*$", 4);
        req_valid = 2'b01;
        do_job(0, 4, 3, 1'b0, 1'b0, 1'b1, 5'd17, 0, 1'b0);

        // Reset in the middle of the pattern load.
        set_pat(0, "wor", 3);
        req_valid = 2'b01;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!sme_ispattern && t < 200);
        check_eq("reach_pat", 64'(sme_ispattern), 64'd1);
        reset = 1'b1;
        #1;
        check_eq("rst_midpat_outs", 64'(all_outs), 64'd0);
        repeat (3) @(negedge clk);
        check_eq("wr_ready_in_reset", 64'(str_wr_ready), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("wr_ready_after_reset", 64'(str_wr_ready), 64'd1);
        t = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid || req_ready != 2'b00 || sme_isstring || sme_ispattern) t++;
        end
        check_eq("quiet_after_reset", 64'(t), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
